// File: rtl/page_walker.sv
// Virtual-to-physical translator: fully-associative TLB in front of a
// configurable-depth page-table walker with superpages and permission faults.
module page_walker #(
  parameter int LEVELS      = 2,
  parameter int IDX_W       = 10,
  parameter int TLB_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vm_enable,
  input  logic        flush_tlb,
  input  logic [31:0] ptbr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_vaddr,
  input  logic        req_write,
  input  logic        req_exec,
  output logic        resp_valid,
  output logic [31:0] resp_paddr,
  output logic        resp_fault,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int VPN_W = 20;
  localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int TI_W  = $clog2(TLB_ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WALK_REQ, S_WALK_WAIT, S_RESP
  } state_t;

  state_t r_state, w_next;

  logic [31:0]      r_vaddr;
  logic             r_write, r_exec;
  logic [VPN_W-1:0] r_base;
  logic [LVL_W-1:0] r_level;
  logic [31:0]      r_paddr;
  logic             r_fault;

  logic [TLB_ENTRIES-1:0] r_tlb_valid;
  logic [VPN_W-1:0]       r_tlb_tag  [TLB_ENTRIES];
  logic [VPN_W-1:0]       r_tlb_ppn  [TLB_ENTRIES];
  logic [2:0]             r_tlb_perm [TLB_ENTRIES];
  logic [LVL_W-1:0]       r_tlb_lvl  [TLB_ENTRIES];
  logic [TI_W-1:0]        r_rr;

  // VPN bits below a leaf at level lvl come straight from the virtual address.
  function automatic logic [VPN_W-1:0] low_mask(input logic [LVL_W-1:0] lvl);
    return (VPN_W'(1) << ((LEVELS - 1 - int'(lvl)) * IDX_W)) - VPN_W'(1);
  endfunction

  // perm = {X, W, R}; a store needs W, else a fetch needs X, else R.
  function automatic logic perm_ok(input logic [2:0] perm, input logic wr, input logic ex);
    if (wr)      return perm[1];
    else if (ex) return perm[2];
    else         return perm[0];
  endfunction

  function automatic logic [VPN_W-1:0] merge(input logic [VPN_W-1:0] ppn,
                                             input logic [VPN_W-1:0] vpn,
                                             input logic [VPN_W-1:0] mask);
    return (ppn & ~mask) | (vpn & mask);
  endfunction

  logic [VPN_W-1:0] w_vpn;
  logic [IDX_W-1:0] w_vpn_idx;
  logic [11:0]      w_mem_off;

  assign w_vpn     = r_vaddr[31:12];
  assign w_vpn_idx = IDX_W'(w_vpn >> ((LEVELS - 1 - int'(r_level)) * IDX_W));
  assign w_mem_off = 12'({w_vpn_idx, 2'b00});

  // TLB lookup and victim selection.
  logic            w_hit, w_hit_eff, w_has_free;
  logic [TI_W-1:0] w_hit_idx, w_free_idx, w_victim;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (r_tlb_valid[i] && (((r_tlb_tag[i] ^ w_vpn) & ~low_mask(r_tlb_lvl[i])) == '0)) begin
        w_hit     = 1'b1;
        w_hit_idx = TI_W'(i);
      end
      if (!r_tlb_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = TI_W'(i);
      end
    end
  end

  assign w_hit_eff = w_hit && !flush_tlb;
  assign w_victim  = w_has_free ? w_free_idx : r_rr;

  logic        w_hit_fault;
  logic [31:0] w_hit_paddr;

  assign w_hit_fault = !perm_ok(r_tlb_perm[w_hit_idx], r_write, r_exec);
  assign w_hit_paddr = {merge(r_tlb_ppn[w_hit_idx], w_vpn, low_mask(r_tlb_lvl[w_hit_idx])),
                        r_vaddr[11:0]};

  // PTE decode for the walk step currently waiting on memory.
  logic             w_pte_v, w_pte_leaf, w_last, w_walk_descend, w_walk_fault, w_fill;
  logic [VPN_W-1:0] w_pte_ppn, w_walk_mask;
  logic [2:0]       w_pte_perm;
  logic [31:0]      w_walk_paddr;

  assign w_pte_v        = mem_resp_data[0];
  assign w_pte_perm     = mem_resp_data[3:1];
  assign w_pte_ppn      = mem_resp_data[31:12];
  assign w_pte_leaf     = mem_resp_data[1] | mem_resp_data[3];
  assign w_last         = (r_level == LVL_W'(LEVELS - 1));
  assign w_walk_mask    = low_mask(r_level);
  assign w_walk_descend = w_pte_v && !w_pte_leaf && !w_last;
  assign w_walk_fault   = !w_pte_v || (!w_pte_leaf && w_last) ||
                          (w_pte_leaf && (((w_pte_ppn & w_walk_mask) != '0) ||
                                          !perm_ok(w_pte_perm, r_write, r_exec)));
  assign w_walk_paddr   = {merge(w_pte_ppn, w_vpn, w_walk_mask), r_vaddr[11:0]};
  assign w_fill         = (r_state == S_WALK_WAIT) && mem_resp_valid &&
                          !w_walk_descend && !w_walk_fault && !flush_tlb;

  // Reserved PTE bits and the page offset of ptbr are intentionally ignored.
  logic w_unused;
  assign w_unused = &{1'b0, mem_resp_data[11:4], ptbr[11:0]};

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM: next state.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (req_valid) w_next = vm_enable ? S_LOOKUP : S_RESP;
      S_LOOKUP:    w_next = w_hit_eff ? S_RESP : S_WALK_REQ;
      S_WALK_REQ:  if (mem_req_ready) w_next = S_WALK_WAIT;
      S_WALK_WAIT: if (mem_resp_valid) w_next = w_walk_descend ? S_WALK_REQ : S_RESP;
      S_RESP:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    unique case (r_state)
      S_IDLE:     req_ready     = 1'b1;
      S_WALK_REQ: mem_req_valid = 1'b1;
      S_RESP:     resp_valid    = 1'b1;
      default: ;
    endcase
  end

  assign resp_paddr = r_paddr;
  assign resp_fault = r_fault;
  assign mem_addr   = {r_base, w_mem_off};

  // Request latch, walk progress, result registers and TLB control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vaddr     <= '0;
      r_write     <= 1'b0;
      r_exec      <= 1'b0;
      r_base      <= '0;
      r_level     <= '0;
      r_paddr     <= '0;
      r_fault     <= 1'b0;
      r_tlb_valid <= '0;
      r_rr        <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (req_valid) begin
          r_vaddr <= req_vaddr;
          r_write <= req_write;
          r_exec  <= req_exec;
          if (!vm_enable) begin
            r_paddr <= req_vaddr;
            r_fault <= 1'b0;
          end
        end
        S_LOOKUP: if (w_hit_eff) begin
          r_paddr <= w_hit_fault ? 32'h0 : w_hit_paddr;
          r_fault <= w_hit_fault;
        end else begin
          r_level <= '0;
          r_base  <= ptbr[31:12];
        end
        S_WALK_WAIT: if (mem_resp_valid) begin
          if (w_walk_descend) begin
            r_base  <= w_pte_ppn;
            r_level <= r_level + 1'b1;
          end else begin
            r_paddr <= w_walk_fault ? 32'h0 : w_walk_paddr;
            r_fault <= w_walk_fault;
          end
        end
        default: ;
      endcase

      if (flush_tlb) begin
        r_tlb_valid <= '0;
      end else if (w_fill) begin
        r_tlb_valid[w_victim] <= 1'b1;
        if (!w_has_free) r_rr <= r_rr + 1'b1;
      end
    end
  end

  // NOTE: entry payload has no reset; the valid bits alone decide whether it is used.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tlb_tag[w_victim]  <= w_vpn;
      r_tlb_ppn[w_victim]  <= w_pte_ppn;
      r_tlb_perm[w_victim] <= w_pte_perm;
      r_tlb_lvl[w_victim]  <= r_level;
    end
  end

endmodule
